// File: rtl/cpu_clock_control_if.sv
// Control-side signal bundle for cpu_clock_control: raw board inputs in, CPU tick and status out.
interface cpu_clock_control_if;
    logic        slow_clk;
    logic        step_btn_n;
    logic        run_sw;
    logic        halt_req;
    logic        cpu_tick;
    logic        running;
    logic        halted;
    logic [15:0] tick_count;

    modport master (
        output slow_clk, step_btn_n, run_sw, halt_req,
        input  cpu_tick, running, halted, tick_count
    );

    modport slave (
        input  slow_clk, step_btn_n, run_sw, halt_req,
        output cpu_tick, running, halted, tick_count
    );
endinterface

// File: rtl/cpu_clock_control.sv
// CPU clock-enable generator: RUN (slow_clk rises), STEP (debounced button) and HALT modes.
// Optional tick counter on tick_count is built only when CLKCTL_TICK_COUNT_EN is defined.
module cpu_clock_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int          CNT_W           = 20
) (
    input  logic               clock_in,
    input  logic               reset,
    cpu_clock_control_if.slave bus
);
    typedef enum logic [1:0] {
        S_STEP = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       slow_sync_q;
    logic             slow_prev_q;
    logic [1:0]       btn_sync_q;
    logic [1:0]       run_sync_q;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             db_pressed_q, db_pressed_d;
    state_t           state_q, state_d;
    logic             tick_q, tick_d;
    logic             running_q;
    logic             halted_q;

    logic rise;
    logic press;
    logic btn_pressed_sync;

    assign rise             = slow_sync_q[1] & ~slow_prev_q;
    assign btn_pressed_sync = ~btn_sync_q[1];

    // The counter measures how long the synced button has disagreed with the accepted level;
    // any cycle of agreement (a bounce back) restarts the measurement.
    always_comb begin
        db_cnt_d     = db_cnt_q;
        db_pressed_d = db_pressed_q;
        if (btn_pressed_sync == db_pressed_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d     = '0;
            db_pressed_d = btn_pressed_sync;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign press = db_pressed_d & ~db_pressed_q;

    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;
        if (bus.halt_req) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_HALT: if (press) state_d = S_STEP;
                S_STEP: begin
                    tick_d = press;
                    if (run_sync_q[1]) state_d = S_RUN;
                end
                S_RUN: begin
                    tick_d = rise;
                    if (!run_sync_q[1]) state_d = S_STEP;
                end
                default: state_d = S_STEP;
            endcase
        end
        // A press tick followed by an immediate RUN-mode rise must not merge into a 2-cycle pulse.
        tick_d = tick_d & ~tick_q;
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            slow_sync_q  <= 2'b00;
            slow_prev_q  <= 1'b0;
            btn_sync_q   <= 2'b11;
            run_sync_q   <= 2'b00;
            db_cnt_q     <= '0;
            db_pressed_q <= 1'b0;
            state_q      <= S_STEP;
            tick_q       <= 1'b0;
            running_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            slow_sync_q  <= {slow_sync_q[0], bus.slow_clk};
            slow_prev_q  <= slow_sync_q[1];
            btn_sync_q   <= {btn_sync_q[0], bus.step_btn_n};
            run_sync_q   <= {run_sync_q[0], bus.run_sw};
            db_cnt_q     <= db_cnt_d;
            db_pressed_q <= db_pressed_d;
            state_q      <= state_d;
            tick_q       <= tick_d;
            running_q    <= (state_d == S_RUN);
            halted_q     <= (state_d == S_HALT);
        end
    end

    assign bus.cpu_tick = tick_q;
    assign bus.running  = running_q;
    assign bus.halted   = halted_q;

`ifdef CLKCTL_TICK_COUNT_EN
    logic [15:0] tick_cnt_q;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            tick_cnt_q <= 16'h0000;
        end else if (tick_q) begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    assign bus.tick_count = tick_cnt_q;
`else
    assign bus.tick_count = 16'h0000;
`endif
endmodule
